// File: rtl/fp_mul_pkg.sv
// Shared widths and FSM state type for the sequential significand multiplier.
package fp_mul_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned CNT_W  = 5;

  // Counter value of the 24th (final) shift-add iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MANT_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple-carry significand adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/mant_add_24bits.sv
// 24-bit ripple-carry adder built from full_adder cells; carry-out extends the sum to 25 bits.
module mant_add_24bits
  import fp_mul_pkg::*;
(
  input  logic [MANT_W-1:0] i_data_one,
  input  logic [MANT_W-1:0] i_data_two,
  input  logic              i_carry,
  output logic [MANT_W-1:0] o_data,
  output logic              o_carry
);

  // Each stage keeps its own carry scalars so the chain is not one self-referencing vector.
  for (genvar i = 0; i < MANT_W; i++) begin : g_fa
    logic cin;
    logic cout;

    if (i == 0) begin : g_first
      assign cin = i_carry;
    end else begin : g_rest
      assign cin = g_fa[i-1].cout;
    end

    full_adder u_fa (
      .i_a    (i_data_one[i]),
      .i_b    (i_data_two[i]),
      .i_c    (cin),
      .o_sum  (o_data[i]),
      .o_carry(cout)
    );
  end

  assign o_carry = g_fa[MANT_W-1].cout;

endmodule

// File: rtl/fp_mant_mul_seq.sv
// Sequential 24x24 shift-add significand multiplier (24 iterations, one per clock).
// Optional zero-operand bypass enabled by defining FP_MANT_ZERO_BYPASS_EN.
module fp_mant_mul_seq
  import fp_mul_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [MANT_W-1:0] i_mant_one,
  input  logic [MANT_W-1:0] i_mant_two,
  output logic              o_ready,
  output logic              o_valid,
  output logic [PROD_W-1:0] o_product,
  output logic              o_norm
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MANT_W-1:0]  mcand_q, mcand_d;
  logic [MANT_W-1:0]  mplier_q, mplier_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0]  prod_q, prod_d;

  logic [MANT_W-1:0]  add_sum;
  logic               add_carry;
  logic [MANT_W:0]    upper;
  logic [PROD_W-1:0]  acc_shift;

  mant_add_24bits u_add (
    .i_data_one(acc_q[PROD_W-1:MANT_W]),
    .i_data_two(mcand_q),
    .i_carry   (1'b0),
    .o_data    (add_sum),
    .o_carry   (add_carry)
  );

  // Upper half plus carry, then the whole {carry, acc} shifted right by one.
  always_comb begin
    upper     = mplier_q[0] ? {add_carry, add_sum} : {1'b0, acc_q[PROD_W-1:MANT_W]};
    acc_shift = {upper, acc_q[MANT_W-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          mcand_d  = i_mant_one;
          mplier_d = i_mant_two;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
`ifdef FP_MANT_ZERO_BYPASS_EN
          if (i_mant_one == '0 || i_mant_two == '0) begin
            prod_d  = '0;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          prod_d  = acc_shift;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_product = prod_q;
  assign o_norm    = prod_q[PROD_W-1];

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Self-checking bench for fp_mant_mul_seq: directed vector table plus busy/reset sequences.
module tb_fp_mant_mul_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [23:0] i_mant_one;
  logic [23:0] i_mant_two;
  logic        o_ready;
  logic        o_valid;
  logic [47:0] o_product;
  logic        o_norm;

  int checks;
  int failures;

  fp_mant_mul_seq dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_mant_one(i_mant_one),
    .i_mant_two(i_mant_two),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_product (o_product),
    .o_norm    (o_norm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] prod;
    logic        norm;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges after the start-sampling edge until o_valid is seen.
  function automatic int exp_lat(input logic [23:0] a, input logic [23:0] b);
`ifdef FP_MANT_ZERO_BYPASS_EN
    if (a == 24'h0 || b == 24'h0) return 0;
`endif
    return 24;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_mul(input logic [23:0] a, input logic [23:0] b, input logic [47:0] ep,
                         input logic en, input string tag);
    int lat;
    i_mant_one = a;
    i_mant_two = b;
    i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start    = 1'b0;
    i_mant_one = ~a;
    i_mant_two = b ^ 24'h5A5A5A;
    lat = 0;
    while (!o_valid && lat < 64) begin
      @(negedge i_clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(a, b)));
    chk({tag, " product"}, 64'(o_product), 64'(ep));
    chk({tag, " norm"}, 64'(o_norm), 64'(en));
    @(negedge i_clk);
    chk({tag, " valid_drop"}, 64'(o_valid), 64'd0);
    chk({tag, " ready_back"}, 64'(o_ready), 64'd1);
    chk({tag, " product_hold"}, 64'(o_product), 64'(ep));
  endtask

  initial begin
    int busy;
    int seen;
    int extra;
    logic [47:0] got;

    checks   = 0;
    failures = 0;

    vecs[0] = '{a: 24'h800000, b: 24'h800000, prod: 48'h400000000000, norm: 1'b0};
    vecs[1] = '{a: 24'hC00000, b: 24'hC00000, prod: 48'h900000000000, norm: 1'b1};
    vecs[2] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, prod: 48'hFFFFFE000001, norm: 1'b1};
    vecs[3] = '{a: 24'h000000, b: 24'hC00000, prod: 48'h000000000000, norm: 1'b0};
    vecs[4] = '{a: 24'hFFFFFF, b: 24'h800000, prod: 48'h7FFFFF800000, norm: 1'b0};
    vecs[5] = '{a: 24'hA00000, b: 24'h900000, prod: 48'h5A0000000000, norm: 1'b0};
    vecs[6] = '{a: 24'h800001, b: 24'h800001, prod: 48'h400001000001, norm: 1'b0};
    vecs[7] = '{a: 24'h000001, b: 24'h000001, prod: 48'h000000000001, norm: 1'b0};

    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_mant_one = '0;
    i_mant_two = '0;
    repeat (3) @(negedge i_clk);
    chk("reset ready", 64'(o_ready), 64'd1);
    chk("reset valid", 64'(o_valid), 64'd0);
    chk("reset product", 64'(o_product), 64'd0);
    chk("reset norm", 64'(o_norm), 64'd0);

    // Start is presented for the very first edge after reset release.
    i_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].norm, $sformatf("vec%0d", i));
    end

    // Start pulse while busy must be ignored and not queued.
    i_mant_one = 24'hC00000;
    i_mant_two = 24'hC00000;
    i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    busy = 0;
    seen = 0;
    got  = '0;
    while (!o_ready && busy < 80) begin
      busy++;
      if (o_valid) begin
        seen++;
        got = o_product;
      end
      if (busy == 6) begin
        i_start    = 1'b1;
        i_mant_one = 24'hFFFFFF;
        i_mant_two = 24'hFFFFFF;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    chk("busy ready_low_cycles", 64'(busy), 64'd25);
    chk("busy valid_pulses", 64'(seen), 64'd1);
    chk("busy product", 64'(got), 64'h900000000000);
    extra = 0;
    repeat (30) begin
      if (o_valid || !o_ready) extra++;
      @(negedge i_clk);
    end
    chk("busy no_queued_op", 64'(extra), 64'd0);

    // Reset at iteration 10 aborts the operation.
    i_mant_one = 24'hA00000;
    i_mant_two = 24'h900000;
    i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("abort busy_before", 64'(o_ready), 64'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort ready", 64'(o_ready), 64'd1);
    chk("abort valid", 64'(o_valid), 64'd0);
    chk("abort product", 64'(o_product), 64'd0);
    chk("abort norm", 64'(o_norm), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    extra = 0;
    repeat (30) begin
      if (o_valid || !o_ready) extra++;
      @(negedge i_clk);
    end
    chk("abort no_valid", 64'(extra), 64'd0);

    // Normal operation resumes after the abort.
    run_mul(24'hC00000, 24'h800000, 48'h600000000000, 1'b0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
